// File: rtl/ed25519_defs.sv
// Shared Ed25519 signing-path definitions: group order L, widths, reducer FSM states.
// Operand length depends on ED25519_MODL_ACC_EN (adds one carry bit for iX+iC).
package ed25519_defs;

    localparam int unsigned W_IN = 512;
    localparam int unsigned W_R  = 253;
    localparam int unsigned W_C  = 256;

    // L = 2^252 + 27742317777372353535851937790883648493
    localparam logic [W_R-1:0] L_ORDER =
        253'h1000000000000000000000000000000014def9dea2f79cd65812631a5cf5d3ed;

`ifdef ED25519_MODL_ACC_EN
    localparam int unsigned N_BITS = W_IN + 1;
`else
    localparam int unsigned N_BITS = W_IN;
`endif

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/ed25519_cond_sub_l.sv
// Combinational conditional subtract: r = (t >= L) ? t - L : t, for t < 2L.
module ed25519_cond_sub_l
    import ed25519_defs::*;
(
    input  logic [W_R:0]   t,
    output logic [W_R-1:0] r
);

    logic [W_R+1:0] diff;

    // The top bit of the widened difference is the borrow; set means t < L.
    always_comb begin
        diff = {1'b0, t} - {2'b00, L_ORDER};
        r    = diff[W_R+1] ? t[W_R-1:0] : diff[W_R-1:0];
    end

endmodule

// File: rtl/ed25519_mod_l_reduce.sv
// Bit-serial reducer: 512-bit operand (optionally plus 256-bit addend) mod Ed25519 L.
// Addend port iC and the extra carry cycle exist only with ED25519_MODL_ACC_EN.
module ed25519_mod_l_reduce
    import ed25519_defs::*;
(
    input  logic            iClk,
    input  logic            iRst,
    input  logic            iStart,
    input  logic [W_IN-1:0] iX,
`ifdef ED25519_MODL_ACC_EN
    input  logic [W_C-1:0]  iC,
`endif
    output logic            oBusy,
    output logic            oDone,
    output logic [W_R-1:0]  oR
);

    state_t              state;
    state_t              next_state;
    logic [9:0]          cnt;
    logic [N_BITS-1:0]   sh;
    logic [N_BITS-1:0]   operand;
    logic [W_R-1:0]      r;
    logic [W_R-1:0]      r_next;
    logic [W_R:0]        t;
    logic                last;

`ifdef ED25519_MODL_ACC_EN
    assign operand = {1'b0, iX} + {{(N_BITS-W_C){1'b0}}, iC};
`else
    assign operand = iX;
`endif

    assign t    = {r, sh[N_BITS-1]};
    assign last = (cnt == 10'(N_BITS - 1));

    ed25519_cond_sub_l u_sub (
        .t (t),
        .r (r_next)
    );

    always_comb begin
        next_state = state;
        oBusy      = 1'b0;
        case (state)
            ST_IDLE: if (iStart) next_state = ST_RUN;
            ST_RUN: begin
                oBusy = 1'b1;
                if (last) next_state = ST_IDLE;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state <= ST_IDLE;
            cnt   <= '0;
            sh    <= '0;
            r     <= '0;
            oDone <= 1'b0;
            oR    <= '0;
        end else begin
            state <= next_state;
            oDone <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (iStart) begin
                        sh  <= operand;
                        r   <= '0;
                        cnt <= '0;
                    end
                end
                ST_RUN: begin
                    r   <= r_next;
                    sh  <= {sh[N_BITS-2:0], 1'b0};
                    cnt <= cnt + 10'd1;
                    if (last) begin
                        oR    <= r_next;
                        oDone <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ed25519_mod_l_reduce.sv
// Self-checking bench for ed25519_mod_l_reduce: directed vector table plus
// sequences for mid-run restart, back-to-back start and mid-run reset.
module tb_ed25519_mod_l_reduce;

    localparam logic [252:0] L =
        253'h1000000000000000000000000000000014def9dea2f79cd65812631a5cf5d3ed;
`ifdef ED25519_MODL_ACC_EN
    localparam int unsigned N   = 513;
    localparam bit          ACC = 1'b1;
`else
    localparam int unsigned N   = 512;
    localparam bit          ACC = 1'b0;
`endif

    typedef struct {
        string        name;
        logic [511:0] x;
        logic [255:0] c;
        logic [252:0] exp;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [511:0] ix = '0;
`ifdef ED25519_MODL_ACC_EN
    logic [255:0] ic = '0;
`endif
    logic         busy;
    logic         done;
    logic [252:0] res;

    int errors = 0;
    int checks = 0;
    logic [252:0] last_r = '0;

    always #5 clk = ~clk;

    ed25519_mod_l_reduce dut (
        .iClk   (clk),
        .iRst   (rst),
        .iStart (start),
        .iX     (ix),
`ifdef ED25519_MODL_ACC_EN
        .iC     (ic),
`endif
        .oBusy  (busy),
        .oDone  (done),
        .oR     (res)
    );

    function automatic logic [252:0] golden(input logic [511:0] x, input logic [255:0] c);
        logic [513:0] s;
        logic [513:0] m;
        s = {2'b00, x};
        if (ACC) s = s + {258'd0, c};
        m = s % {261'd0, L};
        return m[252:0];
    endfunction

    function automatic vec_t mk(input string name, input logic [511:0] x,
                                input logic [255:0] c, input logic [252:0] exp);
        vec_t v;
        v.name = name;
        v.x    = x;
        v.c    = c;
        v.exp  = exp;
        return v;
    endfunction

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic start_op(input string name, input logic [511:0] x, input logic [255:0] c);
        @(negedge clk);
        start = 1'b1;
        ix    = x;
`ifdef ED25519_MODL_ACC_EN
        ic    = c;
`else
        if (c != '0) $display("note: addend ignored without accumulate build");
`endif
        @(posedge clk);
        #1;
        start = 1'b0;
        check({name, "_busy"}, 512'(busy), 512'd1);
        check({name, "_done_low"}, 512'(done), 512'd0);
        check({name, "_r_held"}, 512'(res), 512'(last_r));
    endtask

    // Caller is #1 after the edge numbered 'already' relative to the start edge.
    task automatic wait_done(input string name, input logic [252:0] exp, input int unsigned already);
        int unsigned cyc;
        bit          seen;
        cyc  = already;
        seen = 1'b0;
        while (!seen && cyc < N + 8) begin
            @(posedge clk);
            #1;
            cyc++;
            if (done) seen = 1'b1;
        end
        check({name, "_latency"}, 512'(seen ? cyc : 0), 512'(N));
        check({name, "_r"}, 512'(res), 512'(exp));
        last_r = res;
    endtask

    task automatic reduce(input string name, input logic [511:0] x,
                          input logic [255:0] c, input logic [252:0] exp);
        start_op(name, x, c);
        wait_done(name, exp, 0);
        @(posedge clk);
        #1;
        check({name, "_pulse"}, 512'({done, busy}), 512'd0);
    endtask

    initial begin
        vec_t         vecs[$];
        logic [511:0] lw;
        logic [511:0] x1;
        logic [511:0] x2;
        logic [255:0] rc;

        lw = {259'd0, L};
        vecs.push_back(mk("zero",    '0,              '0, '0));
        vecs.push_back(mk("l_plus5", lw + 512'd5,     '0, 253'd5));
        vecs.push_back(mk("two_l_m1", (lw << 1) - 512'd1, '0, L - 253'd1));
        vecs.push_back(mk("p2_252",  512'd1 << 252,   '0, 253'd1 << 252));
        vecs.push_back(mk("l_exact", lw,              '0, '0));
        vecs.push_back(mk("l_m1",    lw - 512'd1,     '0, L - 253'd1));
        vecs.push_back(mk("lm1_sq",  (lw - 512'd1) * (lw - 512'd1), '0, 253'd1));
        vecs.push_back(mk("full",    '1,              '0, golden('1, '0)));
        vecs.push_back(mk("p2_253",  512'd1 << 253,   '0, golden(512'd1 << 253, '0)));
`ifdef ED25519_MODL_ACC_EN
        vecs.push_back(mk("acc_lm1_1", lw - 512'd1, 256'd1, '0));
        vecs.push_back(mk("acc_full",  '1,          '1,     golden('1, '1)));
`endif

        repeat (3) @(posedge clk);
        #1;
        check("reset_state", 512'({busy, done, res}), 512'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("idle_after_reset", 512'({busy, done, res}), 512'd0);

        for (int i = 0; i < vecs.size(); i++)
            reduce(vecs[i].name, vecs[i].x, vecs[i].c, vecs[i].exp);

        // iStart during RUN must be ignored.
        x1 = lw + 512'd77;
        x2 = 512'd12345;
        start_op("restart", x1, '0);
        repeat (99) @(posedge clk);
        @(negedge clk);
        start = 1'b1;
        ix    = x2;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("restart_busy", 512'(busy), 512'd1);
        wait_done("restart", 253'd77, 100);

        // iStart in the oDone cycle begins the next reduction immediately.
        start_op("b2b_second", x2, '0);
        wait_done("b2b_second", 253'd12345, 0);
        @(posedge clk);
        #1;
        check("b2b_pulse", 512'({done, busy}), 512'd0);

        // Reset mid-run discards everything, including the held result.
        start_op("rst_run", lw + 512'd9, '0);
        repeat (199) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst_mid_run", 512'({busy, done, res}), 512'd0);
        last_r = '0;
        @(negedge clk);
        rst = 1'b0;
        reduce("after_rst", lw + 512'd9, '0, 253'd9);

        for (int i = 0; i < 20; i++) begin
            for (int w = 0; w < 16; w++) x1[w*32 +: 32] = $urandom;
            for (int w = 0; w < 8; w++) rc[w*32 +: 32] = ACC ? $urandom : 32'd0;
            reduce("random", x1, rc, golden(x1, rc));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

endmodule
